// File: rtl/spi_master_shift_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_shift_ctrl
//
// SPI master transfer engine placed directly after the SPI clock generator.
// Each toggle of the divided clock clkgen_ctrl_clk becomes one SCK half-period.
// One DATA_W-bit full-duplex transfer is run per start request, in any of the
// four SPI modes (cpol/cpha), MSB-first or LSB-first.
//
// Ports
//   sys_clk, rst_b      system clock (rising edge), asynchronous active-low reset
//   clkgen_ctrl_clk     divided clock from clkgen; only its toggles are used
//   ctrl_clkgen_en      enable to clkgen, high from start until the transfer ends
//   reg_ctrl_start      one-cycle start pulse
//   reg_ctrl_cpol/cpha  SPI mode bits, reg_ctrl_lsb_first bit order
//   reg_ctrl_txdata     transmit word
//   ctrl_rxdata         last received word, held between transfers
//   ctrl_busy           transfer in progress
//   ctrl_done           one-cycle pulse when ctrl_rxdata has been updated
//   spi_sck/cs_n/mosi   serial bus outputs, spi_miso serial input
//
// Handshake: reg_ctrl_start is honoured only while ctrl_busy is low (FSM in
// IDLE, which includes the ctrl_done cycle); a start seen while busy is
// dropped with no effect. Mode bits and txdata are captured on the accepted
// start and ignored afterwards until ctrl_done.
// -----------------------------------------------------------------------------
module spi_master_shift_ctrl #(
   parameter int DATA_W = 8
) (
   input  logic              sys_clk,
   input  logic              rst_b,
   input  logic              clkgen_ctrl_clk,
   output logic              ctrl_clkgen_en,
   input  logic              reg_ctrl_start,
   input  logic              reg_ctrl_cpol,
   input  logic              reg_ctrl_cpha,
   input  logic              reg_ctrl_lsb_first,
   input  logic [DATA_W-1:0] reg_ctrl_txdata,
   output logic [DATA_W-1:0] ctrl_rxdata,
   output logic              ctrl_busy,
   output logic              ctrl_done,
   output logic              spi_sck,
   output logic              spi_cs_n,
   output logic              spi_mosi,
   input  logic              spi_miso
);

   localparam int CNT_W = $clog2(2 * DATA_W) + 1;
   localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t            state;
   logic              clk_d;
   logic              tick;
   logic              cpol_q;
   logic              cpha_q;
   logic              lsb_q;
   logic [CNT_W-1:0]  edge_cnt;
   logic [DATA_W-1:0] tx_sr;
   logic [DATA_W-1:0] rx_sr;

   // The clkgen output level is not reset when disabled, so only its
   // toggles carry information.
   assign tick = clkgen_ctrl_clk ^ clk_d;

   // Bit that leaves the transmit shift register next.
   function automatic logic tx_head(input logic [DATA_W-1:0] w, input logic lsb);
      return lsb ? w[0] : w[DATA_W-1];
   endfunction

   // Transmit shift register after one bit has been consumed.
   function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] w, input logic lsb);
      return lsb ? (w >> 1) : (w << 1);
   endfunction

   always_ff @(posedge sys_clk or negedge rst_b) begin
      if (!rst_b) begin
         state          <= IDLE;
         clk_d          <= 1'b0;
         cpol_q         <= 1'b0;
         cpha_q         <= 1'b0;
         lsb_q          <= 1'b0;
         edge_cnt       <= '0;
         tx_sr          <= '0;
         rx_sr          <= '0;
         ctrl_clkgen_en <= 1'b0;
         ctrl_rxdata    <= '0;
         ctrl_busy      <= 1'b0;
         ctrl_done      <= 1'b0;
         spi_sck        <= 1'b0;
         spi_cs_n       <= 1'b1;
         spi_mosi       <= 1'b0;
      end else begin
         clk_d     <= clkgen_ctrl_clk;
         ctrl_done <= 1'b0;
         case (state)
            IDLE: begin
               // SCK follows the live idle level until a transfer is accepted.
               spi_sck <= reg_ctrl_cpol;
               if (reg_ctrl_start) begin
                  cpol_q         <= reg_ctrl_cpol;
                  cpha_q         <= reg_ctrl_cpha;
                  lsb_q          <= reg_ctrl_lsb_first;
                  rx_sr          <= '0;
                  spi_cs_n       <= 1'b0;
                  ctrl_clkgen_en <= 1'b1;
                  ctrl_busy      <= 1'b1;
                  state          <= SETUP;
                  // With cpha=0 the first bit must be valid before the leading edge.
                  if (!reg_ctrl_cpha) begin
                     spi_mosi <= tx_head(reg_ctrl_txdata, reg_ctrl_lsb_first);
                     tx_sr    <= tx_shift(reg_ctrl_txdata, reg_ctrl_lsb_first);
                  end else begin
                     tx_sr    <= reg_ctrl_txdata;
                  end
               end
            end
            SETUP: begin
               spi_sck <= cpol_q;
               if (tick) begin
                  edge_cnt <= '0;
                  state    <= XFER;
               end
            end
            XFER: begin
               if (tick) begin
                  spi_sck  <= ~spi_sck;
                  edge_cnt <= edge_cnt + CNT_W'(1);
                  // Even edges are leading edges; the sampling edge is the
                  // one whose parity matches cpha, the other one shifts out.
                  if (edge_cnt[0] == cpha_q) begin
                     rx_sr <= lsb_q ? {spi_miso, rx_sr[DATA_W-1:1]}
                                    : {rx_sr[DATA_W-2:0], spi_miso};
                  end else if (edge_cnt != LAST_EDGE) begin
                     spi_mosi <= tx_head(tx_sr, lsb_q);
                     tx_sr    <= tx_shift(tx_sr, lsb_q);
                  end
                  if (edge_cnt == LAST_EDGE) begin
                     state <= HOLD;
                  end
               end
            end
            HOLD: begin
               spi_sck <= cpol_q;
               if (tick) begin
                  spi_cs_n       <= 1'b1;
                  ctrl_clkgen_en <= 1'b0;
                  ctrl_busy      <= 1'b0;
                  spi_mosi       <= 1'b0;
                  ctrl_rxdata    <= rx_sr;
                  ctrl_done      <= 1'b1;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_shift_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_master_shift_ctrl
//
// Directed bench for spi_master_shift_ctrl (DATA_W = 8). Contains a clkgen
// model (toggle every dl+1 cycles while enabled) and an SPI slave model that
// samples MOSI / drives MISO according to the mode it is told, and records
// edge count, SCK level lengths and CS setup/hold times.
// -----------------------------------------------------------------------------
module tb_spi_master_shift_ctrl;

   localparam int W = 8;

   logic         sys_clk = 1'b0;
   logic         rst_b = 1'b1;
   logic         clkgen_ctrl_clk = 1'b0;
   logic         ctrl_clkgen_en;
   logic         reg_ctrl_start = 1'b0;
   logic         reg_ctrl_cpol = 1'b0;
   logic         reg_ctrl_cpha = 1'b0;
   logic         reg_ctrl_lsb_first = 1'b0;
   logic [W-1:0] reg_ctrl_txdata = '0;
   logic [W-1:0] ctrl_rxdata;
   logic         ctrl_busy;
   logic         ctrl_done;
   logic         spi_sck;
   logic         spi_cs_n;
   logic         spi_mosi;
   logic         spi_miso = 1'b0;

   int checks = 0;
   int errors = 0;

   spi_master_shift_ctrl #(.DATA_W(W)) dut (
      .sys_clk            (sys_clk),
      .rst_b              (rst_b),
      .clkgen_ctrl_clk    (clkgen_ctrl_clk),
      .ctrl_clkgen_en     (ctrl_clkgen_en),
      .reg_ctrl_start     (reg_ctrl_start),
      .reg_ctrl_cpol      (reg_ctrl_cpol),
      .reg_ctrl_cpha      (reg_ctrl_cpha),
      .reg_ctrl_lsb_first (reg_ctrl_lsb_first),
      .reg_ctrl_txdata    (reg_ctrl_txdata),
      .ctrl_rxdata        (ctrl_rxdata),
      .ctrl_busy          (ctrl_busy),
      .ctrl_done          (ctrl_done),
      .spi_sck            (spi_sck),
      .spi_cs_n           (spi_cs_n),
      .spi_mosi           (spi_mosi),
      .spi_miso           (spi_miso)
   );

   // ---------------- clock / reset ----------------
   always #5 sys_clk = ~sys_clk;

   // ---------------- clkgen model ----------------
   int dl = 0;
   int cg_cnt = 0;
   always @(posedge sys_clk) begin
      if (!ctrl_clkgen_en) begin
         cg_cnt <= 0;
      end else if (cg_cnt == dl) begin
         cg_cnt          <= 0;
         clkgen_ctrl_clk <= ~clkgen_ctrl_clk;
      end else begin
         cg_cnt <= cg_cnt + 1;
      end
   end

   // ---------------- slave model ----------------
   logic         m_cpol = 1'b0;
   logic         m_cpha = 1'b0;
   logic         m_lsb = 1'b0;
   logic [W-1:0] slave_word = '0;
   logic [W-1:0] s_tx = '0;
   logic [W-1:0] s_rx = '0;
   logic         first_mosi = 1'b0;
   logic         cs_prev = 1'b1;
   logic         sck_prev = 1'b0;
   int cyc = 0;
   int s_edges = 0;
   int s_idx = 0;
   int s_nsamp = 0;
   int gap_min = 0;
   int gap_max = 0;
   int setup_cyc = 0;
   int hold_cyc = 0;
   int cs_fall_cyc = 0;
   int last_edge_cyc = 0;
   int done_cnt = 0;

   function automatic logic sbit(input logic [W-1:0] w, input int i, input logic lsb);
      return lsb ? w[i] : w[W-1-i];
   endfunction

   always @(negedge sys_clk) begin
      int gap;
      cyc++;
      if (cs_prev && !spi_cs_n) begin
         s_edges     = 0;
         s_idx       = 0;
         s_nsamp     = 0;
         s_rx        = '0;
         s_tx        = slave_word;
         cs_fall_cyc = cyc;
         gap_min     = 1000;
         gap_max     = 0;
         if (!m_cpha) begin
            spi_miso = sbit(s_tx, 0, m_lsb);
            s_idx    = 1;
         end
      end else if (!spi_cs_n && (spi_sck !== sck_prev)) begin
         if (s_edges == 0) begin
            setup_cyc = cyc - cs_fall_cyc;
         end else begin
            gap = cyc - last_edge_cyc;
            if (gap < gap_min) gap_min = gap;
            if (gap > gap_max) gap_max = gap;
         end
         last_edge_cyc = cyc;
         // leading edge leaves the idle level; cpha picks the sampling edge
         if ((spi_sck !== m_cpol) ^ m_cpha) begin
            if (s_nsamp == 0) first_mosi = spi_mosi;
            s_rx = m_lsb ? {spi_mosi, s_rx[W-1:1]} : {s_rx[W-2:0], spi_mosi};
            s_nsamp++;
         end else begin
            if (s_idx < W) spi_miso = sbit(s_tx, s_idx, m_lsb);
            s_idx++;
         end
         s_edges++;
      end else if (!cs_prev && spi_cs_n) begin
         hold_cyc = cyc - last_edge_cyc;
      end
      cs_prev  = spi_cs_n;
      sck_prev = spi_sck;
   end

   always @(negedge sys_clk) begin
      if (ctrl_done) done_cnt++;
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #2;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_xfer(input logic [W-1:0] tx, input logic cp, input logic ch, input logic lsb);
      reg_ctrl_txdata    = tx;
      reg_ctrl_cpol      = cp;
      reg_ctrl_cpha      = ch;
      reg_ctrl_lsb_first = lsb;
      m_cpol             = cp;
      m_cpha             = ch;
      m_lsb              = lsb;
      reg_ctrl_start     = 1'b1;
      step(1);
      reg_ctrl_start     = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max_cyc);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (ctrl_done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         step(1);
      end
      check(tag, seen, 1'b1);
   endtask

   // ---------------- directed sequence ----------------
   logic [W-1:0] first_rx;
   bit           reached;

   initial begin
      #1 rst_b = 1'b0;
      step(2);
      check("rst_cs_n", spi_cs_n, 1'b1);
      check("rst_sck", spi_sck, 1'b0);
      check("rst_mosi", spi_mosi, 1'b0);
      check("rst_busy", ctrl_busy, 1'b0);
      check("rst_done", ctrl_done, 1'b0);
      check("rst_en", ctrl_clkgen_en, 1'b0);
      check("rst_rxdata", ctrl_rxdata, 8'h00);
      rst_b = 1'b1;
      step(2);

      // 1: mode 0, DL=0, MSB-first
      dl = 0; done_cnt = 0; slave_word = 8'h3C;
      start_xfer(8'hA5, 1'b0, 1'b0, 1'b0);
      check("t1_busy", ctrl_busy, 1'b1);
      check("t1_cs_low", spi_cs_n, 1'b0);
      check("t1_en", ctrl_clkgen_en, 1'b1);
      check("t1_mosi_first", spi_mosi, 1'b1);
      wait_done("t1_done_seen", 200);
      check("t1_rxdata", ctrl_rxdata, 8'h3C);
      step(2);
      check("t1_mosi_word", s_rx, 8'hA5);
      check("t1_edges", s_edges, 16);
      check("t1_done_cnt", done_cnt, 1);
      check("t1_idle_busy", ctrl_busy, 1'b0);
      check("t1_idle_cs", spi_cs_n, 1'b1);
      check("t1_idle_mosi", spi_mosi, 1'b0);
      check("t1_idle_en", ctrl_clkgen_en, 1'b0);

      // 2: mode 3, DL=3
      dl = 3; done_cnt = 0; slave_word = 8'hC5;
      reg_ctrl_cpol = 1'b1;
      step(2);
      check("t2_sck_idle", spi_sck, 1'b1);
      start_xfer(8'h5A, 1'b1, 1'b1, 1'b0);
      wait_done("t2_done_seen", 400);
      check("t2_rxdata", ctrl_rxdata, 8'hC5);
      step(2);
      check("t2_mosi_word", s_rx, 8'h5A);
      check("t2_edges", s_edges, 16);
      check("t2_gap_min", gap_min, 4);
      check("t2_gap_max", gap_max, 4);
      check("t2_cs_setup", setup_cyc >= 4, 1'b1);
      check("t2_cs_hold", hold_cyc >= 4, 1'b1);
      check("t2_sck_idle_after", spi_sck, 1'b1);
      check("t2_done_cnt", done_cnt, 1);

      // 3: mode 1, LSB-first
      dl = 1; done_cnt = 0; slave_word = 8'h80;
      start_xfer(8'h01, 1'b0, 1'b1, 1'b1);
      wait_done("t3_done_seen", 300);
      check("t3_rxdata", ctrl_rxdata, 8'h80);
      step(2);
      check("t3_first_mosi", first_mosi, 1'b1);
      check("t3_mosi_word", s_rx, 8'h01);
      check("t3_edges", s_edges, 16);

      // 4: start while busy is ignored; inputs changed mid-transfer have no effect
      dl = 1; done_cnt = 0; slave_word = 8'h69;
      start_xfer(8'h96, 1'b0, 1'b0, 1'b0);
      step(10);
      check("t4_busy_mid", ctrl_busy, 1'b1);
      reg_ctrl_txdata    = 8'hFF;
      reg_ctrl_cpha      = 1'b1;
      reg_ctrl_lsb_first = 1'b1;
      reg_ctrl_start     = 1'b1;
      step(1);
      reg_ctrl_start     = 1'b0;
      wait_done("t4_done_seen", 300);
      check("t4_rxdata", ctrl_rxdata, 8'h69);
      step(5);
      check("t4_mosi_word", s_rx, 8'h96);
      check("t4_edges", s_edges, 16);
      check("t4_done_cnt", done_cnt, 1);
      check("t4_no_restart", spi_cs_n, 1'b1);

      // 5: reset at SCK edge 5 of a mode 2 transfer
      dl = 1; done_cnt = 0; slave_word = 8'h5A;
      start_xfer(8'h0F, 1'b1, 1'b0, 1'b0);
      reached = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (s_edges == 5) begin
            reached = 1'b1;
            break;
         end
         step(1);
      end
      check("t5_edge5_reached", reached, 1'b1);
      rst_b = 1'b0;
      #1;
      check("t5_rst_cs_n", spi_cs_n, 1'b1);
      check("t5_rst_sck", spi_sck, 1'b0);
      check("t5_rst_busy", ctrl_busy, 1'b0);
      check("t5_rst_en", ctrl_clkgen_en, 1'b0);
      check("t5_rst_mosi", spi_mosi, 1'b0);
      check("t5_rst_rxdata", ctrl_rxdata, 8'h00);
      step(3);
      rst_b = 1'b1;
      step(3);
      check("t5_no_done", done_cnt, 0);
      slave_word = 8'h24;
      start_xfer(8'hC3, 1'b1, 1'b0, 1'b0);
      wait_done("t5_done_seen", 300);
      check("t5_rxdata", ctrl_rxdata, 8'h24);
      step(2);
      check("t5_mosi_word", s_rx, 8'hC3);
      check("t5_edges", s_edges, 16);
      check("t5_done_cnt", done_cnt, 1);

      // 6: start in the done cycle, DL=1
      dl = 1; done_cnt = 0; slave_word = 8'h81;
      start_xfer(8'h3C, 1'b0, 1'b0, 1'b0);
      wait_done("t6_done1_seen", 300);
      check("t6_rxdata1", ctrl_rxdata, 8'h81);
      first_rx        = s_rx;
      slave_word      = 8'h42;
      reg_ctrl_txdata = 8'hE7;
      reg_ctrl_start  = 1'b1;
      step(1);
      reg_ctrl_start  = 1'b0;
      check("t6_back_to_back_cs", spi_cs_n, 1'b0);
      check("t6_back_to_back_busy", ctrl_busy, 1'b1);
      check("t6_mosi_word1", first_rx, 8'h3C);
      wait_done("t6_done2_seen", 300);
      check("t6_rxdata2", ctrl_rxdata, 8'h42);
      step(2);
      check("t6_mosi_word2", s_rx, 8'hE7);
      check("t6_done_cnt", done_cnt, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
